// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO drain arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Words granted per burst: zero means one word, anything above max saturates.
    function automatic int clamp_burst(input int cfg, input int max);
        if (cfg == 0)
            return 1;
        if (cfg > max)
            return max;
        return cfg;
    endfunction

endpackage

// File: rtl/fifo_rr_drain_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above base, with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    off;
    logic [IW:0]    sum;

    // Rotate via a doubled vector, priority-search from bit 0, then undo the rotation.
    always_comb begin
        dbl   = {req, req};
        rot   = dbl[base +: N];
        found = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = (IW + 1)'(i);
            end
        end
        sum = {1'b0, base} + off;
        if (sum >= (IW + 1)'(N))
            sum = sum - (IW + 1)'(N);
        idx = sum[IW-1:0];
    end

endmodule

// File: rtl/fifo_rr_drain_arb.sv
// Round-robin drain of NUM_SRC FWFT FIFOs into one registered valid/ready stream.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | arbitration cycle; grant the next non-empty source if enabled
// ST_BURST | popping the granted source until blen words or it runs empty
module fifo_rr_drain_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_MAX  = 8,
    localparam int BW        = $clog2(BURST_MAX + 1),
    localparam int IW        = idx_width(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [BW-1:0]                 cfg_burst,
    input  logic [NUM_SRC-1:0]            src_empty,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_dat,
    output logic [NUM_SRC-1:0]            src_rd_ena,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_dat,
    output logic [IW-1:0]                 m_src,
    output logic                          m_last,
    output logic                          busy,
    output logic [IW-1:0]                 gnt_id
);

    arb_state_t            state, state_nxt;
    logic [IW-1:0]         rr_ptr;
    logic [BW-1:0]         blen;
    logic [BW-1:0]         beat_cnt;
    logic [DATA_WIDTH-1:0] src_word [NUM_SRC];

    logic                  ld;
    logic                  cur_empty;
    logic                  last_beat;
    logic                  pop;
    logic                  grant;
    logic                  burst_end;
    logic                  pick_found;
    logic [IW-1:0]         pick_idx;
    logic [IW-1:0]         gnt_next;

    rr_pick #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_pick (
        .req   (~src_empty),
        .base  (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Split the flat data bus into per-source words.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++)
            src_word[i] = src_dat[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Output-register handshake, pop strobe and burst bookkeeping.
    always_comb begin
        ld         = !m_valid || m_ready;
        cur_empty  = src_empty[gnt_id];
        last_beat  = (beat_cnt == blen - 1'b1);
        pop        = (state == ST_BURST) && ld && !cur_empty;
        gnt_next   = (int'(gnt_id) == NUM_SRC - 1) ? '0 : gnt_id + 1'b1;
        src_rd_ena = '0;
        if (pop)
            src_rd_ena[gnt_id] = 1'b1;
    end

    // Next-state logic; a burst ends on its final pop or when the source dries up.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        burst_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && pick_found) begin
                    grant     = 1'b1;
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (ld && (cur_empty || last_beat)) begin
                    burst_end = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Grant, pointer and output-register updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            gnt_id   <= '0;
            blen     <= '0;
            beat_cnt <= '0;
            m_valid  <= 1'b0;
            m_dat    <= '0;
            m_src    <= '0;
            m_last   <= 1'b0;
        end else begin
            if (grant) begin
                gnt_id   <= pick_idx;
                blen     <= BW'(clamp_burst(int'(cfg_burst), BURST_MAX));
                beat_cnt <= '0;
            end
            if (burst_end)
                rr_ptr <= gnt_next;
            if (pop) begin
                m_dat    <= src_word[gnt_id];
                m_src    <= gnt_id;
                m_valid  <= 1'b1;
                m_last   <= last_beat;
                beat_cnt <= beat_cnt + 1'b1;
            end else if (ld) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign busy = (state == ST_BURST);

endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// Directed bench for fifo_rr_drain_arb with queue-modelled FWFT source FIFOs.
module tb_fifo_rr_drain_arb;

    localparam int NS = 4;
    localparam int DW = 16;
    localparam int BM = 8;
    localparam int BW = $clog2(BM + 1);
    localparam int IW = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic [BW-1:0]      cfg_burst = '0;
    logic [NS-1:0]      src_empty = '1;
    logic [NS*DW-1:0]   src_dat = '0;
    logic [NS-1:0]      src_rd_ena;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic [DW-1:0]      m_dat;
    logic [IW-1:0]      m_src;
    logic               m_last;
    logic               busy;
    logic [IW-1:0]      gnt_id;

    fifo_rr_drain_arb #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg_burst  (cfg_burst),
        .src_empty  (src_empty),
        .src_dat    (src_dat),
        .src_rd_ena (src_rd_ena),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_dat      (m_dat),
        .m_src      (m_src),
        .m_last     (m_last),
        .busy       (busy),
        .gnt_id     (gnt_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] fq [NS][$];
    logic [IW-1:0] lsrc [$];
    logic [DW-1:0] ldat [$];
    logic          llast [$];
    int            lcyc [$];
    logic [IW-1:0] esrc [$];
    logic [DW-1:0] edat [$];
    logic          elast [$];

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat;
    logic [IW-1:0] prev_src;
    logic          prev_last;
    logic [NS-1:0] pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int s, input int k);
        return 16'hA000 | DW'(s << 8) | DW'(k);
    endfunction

    task automatic refresh();
        for (int i = 0; i < NS; i++) begin
            src_empty[i] = (fq[i].size() == 0);
            src_dat[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic load(input int s, input int n);
        for (int k = 0; k < n; k++)
            fq[s].push_back(word(s, k));
        refresh();
    endtask

    task automatic clear_logs();
        lsrc.delete(); ldat.delete(); llast.delete(); lcyc.delete();
        esrc.delete(); edat.delete(); elast.delete();
    endtask

    task automatic exp_push(input int s, input int k, input logic l);
        esrc.push_back(IW'(s));
        edat.push_back(word(s, k));
        elast.push_back(l);
    endtask

    // One clock: sample at negedge, then apply FIFO pops just after the rising edge.
    task automatic tick();
        @(negedge clk);
        pend = src_rd_ena;
        check("rd_onehot", 32'($onehot0(src_rd_ena)), 1);
        check("rd_on_empty", 32'(src_rd_ena & src_empty), 0);
        if (!busy)
            check("rd_in_idle", 32'(src_rd_ena), 0);
        if (m_valid && !m_ready)
            check("rd_while_stall", 32'(src_rd_ena), 0);
        if (prev_stall) begin
            check("stall_dat", 32'(m_dat), 32'(prev_dat));
            check("stall_src", 32'(m_src), 32'(prev_src));
            check("stall_last", 32'(m_last), 32'(prev_last));
        end
        prev_stall = m_valid && !m_ready;
        prev_dat   = m_dat;
        prev_src   = m_src;
        prev_last  = m_last;
        if (m_valid && m_ready) begin
            lsrc.push_back(m_src);
            ldat.push_back(m_dat);
            llast.push_back(m_last);
            lcyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++)
            if (pend[i] && fq[i].size() != 0)
                void'(fq[i].pop_front());
        refresh();
        cyc++;
    endtask

    task automatic run_until(input int n, input int budget);
        int b;
        b = 0;
        while (lsrc.size() < n && b < budget) begin
            tick();
            b++;
        end
        if (lsrc.size() < n)
            check("timeout", 32'(lsrc.size()), 32'(n));
    endtask

    task automatic check_log(input string tag);
        int n;
        check({tag, "_len"}, 32'(lsrc.size()), 32'(esrc.size()));
        n = (lsrc.size() < esrc.size()) ? lsrc.size() : esrc.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_src%0d", tag, i), 32'(lsrc[i]), 32'(esrc[i]));
            check($sformatf("%s_dat%0d", tag, i), 32'(ldat[i]), 32'(edat[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(llast[i]), 32'(elast[i]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NS; i++)
            fq[i].delete();
        refresh();
        clear_logs();
        prev_stall = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_dat", 32'(m_dat), 0);
        check("rst_m_src", 32'(m_src), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt_id", 32'(gnt_id), 0);
        check("rst_rd_ena", 32'(src_rd_ena), 0);

        // Single source longer than a burst: 4 with last, regrant, 2 without last
        enable = 1'b1;
        cfg_burst = 4'd4;
        load(2, 6);
        cyc = 0;
        for (int k = 0; k < 6; k++)
            exp_push(2, k, k == 3);
        run_until(6, 40);
        repeat (3) tick();
        check_log("t1");
        if (lcyc.size() >= 5) begin
            check("t1_first_latency", 32'(lcyc[0]), 2);
            check("t1_steady", 32'(lcyc[3]), 5);
            check("t1_regrant_gap", 32'(lcyc[4]), 7);
        end
        check("t1_busy_end", 32'(busy), 0);

        // Four full sources, bursts of 2, continuous ready
        do_reset();
        enable = 1'b1;
        cfg_burst = 4'd2;
        for (int s = 0; s < NS; s++)
            load(s, 8);
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < NS; s++) begin
                exp_push(s, 2*r, 1'b0);
                exp_push(s, 2*r + 1, 1'b1);
            end
        run_until(32, 200);
        repeat (3) tick();
        check_log("t2");
        check("t2_drained", 32'(fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()), 0);

        // Same, with random backpressure
        do_reset();
        enable = 1'b1;
        cfg_burst = 4'd2;
        for (int s = 0; s < NS; s++)
            load(s, 8);
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < NS; s++) begin
                exp_push(s, 2*r, 1'b0);
                exp_push(s, 2*r + 1, 1'b1);
            end
        for (int b = 0; b < 600 && lsrc.size() < 32; b++) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        m_ready = 1'b1;
        repeat (3) tick();
        check_log("t3");

        // cfg_burst = 0 gives one-word bursts, alternating sources
        do_reset();
        enable = 1'b1;
        cfg_burst = 4'd0;
        load(0, 2);
        load(1, 2);
        exp_push(0, 0, 1'b1);
        exp_push(1, 0, 1'b1);
        exp_push(0, 1, 1'b1);
        exp_push(1, 1, 1'b1);
        run_until(4, 40);
        repeat (3) tick();
        check_log("t4a");

        // cfg_burst = 15 saturates at 8
        do_reset();
        enable = 1'b1;
        cfg_burst = 4'd15;
        load(3, 9);
        for (int k = 0; k < 9; k++)
            exp_push(3, k, k == 7);
        run_until(9, 60);
        repeat (3) tick();
        check_log("t4b");

        // enable dropped mid-burst: burst completes, no new grant until re-enabled
        do_reset();
        enable = 1'b1;
        cfg_burst = 4'd4;
        load(1, 5);
        tick();
        tick();
        enable = 1'b0;
        check("t5_busy_mid", 32'(busy), 1);
        repeat (15) tick();
        check("t5_words_disabled", 32'(lsrc.size()), 4);
        check("t5_busy_disabled", 32'(busy), 0);
        check("t5_left", 32'(fq[1].size()), 1);
        check("t5_rd_disabled", 32'(src_rd_ena), 0);
        enable = 1'b1;
        for (int k = 0; k < 5; k++)
            exp_push(1, k, k == 3);
        run_until(5, 20);
        repeat (3) tick();
        check_log("t5");

        // Asynchronous reset mid-burst; arbitration restarts from source 0
        do_reset();
        enable = 1'b1;
        cfg_burst = 4'd8;
        load(1, 1);
        load(2, 8);
        run_until(3, 30);
        check("t6_pre_src", 32'(lsrc.size() >= 3 ? lsrc[2] : 2'd0), 2);
        check("t6_pre_valid", 32'(m_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_m_valid", 32'(m_valid), 0);
        check("t6_rst_m_dat", 32'(m_dat), 0);
        check("t6_rst_m_src", 32'(m_src), 0);
        check("t6_rst_m_last", 32'(m_last), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_gnt", 32'(gnt_id), 0);
        check("t6_rst_rd", 32'(src_rd_ena), 0);
        load(0, 2);
        load(3, 2);
        clear_logs();
        prev_stall = 1'b0;
        tick();
        rst = 1'b0;
        exp_push(0, 0, 1'b0);
        exp_push(0, 1, 1'b0);
        run_until(3, 40);
        check("t6_regrant_third_src", 32'(lsrc.size() >= 3 ? lsrc[2] : 2'd0), 2);
        while (lsrc.size() > 2) begin
            void'(lsrc.pop_back());
            void'(ldat.pop_back());
            void'(llast.pop_back());
        end
        check_log("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_rr_drain_arb.md
Name: fifo_rr_drain_arb

Overview:
Round-robin scheduler that drains NUM_SRC first-word-fall-through sync FIFOs into one registered valid/ready output stream. Each source is granted for a burst of up to cfg_burst words. The burst ends early if that source's FIFO runs empty. The block sits between per-channel simple_fifo_sync instances and a shared downstream consumer (e.g. a link framer or DMA writer).

Parameters:
NUM_SRC, 4, number of source FIFOs (2..16)
DATA_WIDTH, 16, word width, same as the source FIFO DATA_WIDTH
BURST_MAX, 8, maximum words per grant (>=1)
BW, $clog2(BURST_MAX+1), width of cfg_burst (localparam)
IW, $clog2(NUM_SRC) (min 1), width of source index (localparam)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  1 = new grants allowed
cfg_burst  in  BW  words per grant; sampled at grant time
src_empty  in  NUM_SRC  per-source FIFO rd_empty
src_dat  in  NUM_SRC*DATA_WIDTH  per-source FWFT rd_dat; source i occupies bits [i*DW +: DW]
src_rd_ena  out  NUM_SRC  per-source pop strobe (combinational)
m_valid  out  1  output word valid
m_ready  in  1  downstream accept
m_dat  out  DATA_WIDTH  output word
m_src  out  IW  index of the source that produced m_dat
m_last  out  1  word is the final word of a full-length burst
busy  out  1  a grant is active (state BURST)
gnt_id  out  IW  currently or most recently granted source

Behaviour:
- Reset values: state=IDLE; m_valid=0, m_dat=0, m_src=0, m_last=0, busy=0, gnt_id=0; rr_ptr=0; beat_cnt=0.
- Reset is legal mid-burst. The output register is cleared. The source FIFOs are not touched and may lose at most the word already popped into m_dat.
- Output register load condition: ld = !m_valid || m_ready.
- Transfer: a word moves downstream when m_valid && m_ready.
- m_dat, m_src and m_last are held stable while m_valid && !m_ready.
- State IDLE:
  - If enable && |(~src_empty), pick the first non-empty source searching from rr_ptr upward, with wrap-around.
  - Register gnt_id, latch blen = (cfg_burst==0 ? 1 : min(cfg_burst, BURST_MAX)), clear beat_cnt, go to BURST.
  - No pop occurs in the grant cycle.
- State BURST, every cycle:
  - pop = ld && !src_empty[gnt_id]; src_rd_ena[gnt_id] = pop.
  - On pop: m_dat <= src_dat[gnt_id], m_src <= gnt_id, m_valid <= 1, m_last <= (beat_cnt == blen-1), beat_cnt++.
  - On pop with beat_cnt == blen-1: go to IDLE and set rr_ptr <= gnt_id+1 (mod NUM_SRC).
  - If ld && src_empty[gnt_id]: the burst ends early with no pop. Go to IDLE, rr_ptr <= gnt_id+1, and no m_last is ever emitted for that burst.
  - If !ld: stall with no pop and no state change.
- In IDLE and on any cycle with no pop: when ld, m_valid <= 0.
- Invariants:
  - src_rd_ena is at most one-hot.
  - src_rd_ena is never asserted for an empty source.
  - src_rd_ena is zero in IDLE.
- Latency: source goes non-empty at cycle 0 (block idle, enabled) → grant registered at edge 1 → pop in cycle 1 → m_valid at cycle 2. Steady-state throughput is 1 word/cycle within a burst.
- Grant switch costs one idle cycle, the IDLE/arbitration cycle.
- enable deasserted mid-burst: the current burst completes normally; no new grant is issued.
- cfg_burst changes mid-burst: no effect until the next grant.
- Fairness: after a grant, the granted source has the lowest priority. No source waits more than NUM_SRC-1 grants.
- busy = (state==BURST).

Decomposition:
- Package fifo_arb_pkg holds:
  - state encoding (ST_IDLE, ST_BURST);
  - helper function clamp_burst(cfg, max);
  - idx-width function returning max(1, clog2(n)).
- Sub-module rr_pick: combinational round-robin picker. Inputs are the req vector and base pointer; outputs are found and idx. Implement it as a doubled-vector priority search.
- Everything else stays in fifo_rr_drain_arb.

Test Plan:
- NUM_SRC=4, cfg_burst=4, m_ready=1; only src2 holds 6 words (A0..A5). Expect A0..A3 on m_dat with m_src=2 and m_last only on A3, then an idle cycle, a regrant of src2, A4 and A5, then early end with no m_last.
- All 4 sources hold 8 words, cfg_burst=2. Expect grant order 0,1,2,3,0,… with 2 words each. m_last is set on every second word. Total 32 words, no loss or duplication.
- Same setup with m_ready toggled randomly (50%). Expect m_dat/m_src stable while stalled, src_rd_ena never asserted while m_valid && !m_ready, and an output sequence identical to the previous test.
- cfg_burst=0 then cfg_burst=15 (BURST_MAX=8). Expect 1-word bursts for 0, and 8-word bursts with m_last on the 8th word for 15.
- Mid-burst enable=0 with src1 holding 5 words, cfg_burst=4. Expect the burst of 4 to complete, then busy=0 and no further pops while disabled. Re-enabling yields the remaining word.
- Assert rst for one cycle mid-burst while m_valid=1. Expect all outputs zero asynchronously, rr_ptr=0, src_rd_ena=0. After release, arbitration restarts from source 0.
